// File: rtl/nbcac_21di_decoder_seq.sv
// Sequential NBCAC-21 decoder: folds LANES codeword bits per cycle into a weighted sum.
// Flags codewords whose sum exceeds the 21-bit range.
//
// state | meaning
// IDLE  | waiting for a codeword, in_ready high
// ACC   | accumulating LANES weighted bits per cycle
// DONE  | result presented until out_ready
module nbcac_21di_decoder_seq #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [29:0] in_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [20:0] out_data,
    output logic        out_err,
    output logic        busy
);
    localparam int ROUNDS = 30 / LANES;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 3 || LANES == 5 ||
              LANES == 6 || LANES == 10 || LANES == 15 || LANES == 30)) begin : g_bad_lanes
            $fatal(1, "nbcac_21di_decoder_seq: LANES must divide 30");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [29:0] r_shift;
    logic [21:0] r_acc;
    logic [4:0]  r_round;
    logic [21:0] w_sum;
    logic        w_last;

    function automatic logic [21:0] weight(input int k);
        case (k)
            1:  return 22'd1;
            2:  return 22'd1028458;
            3:  return 22'd635622;
            4:  return 22'd392836;
            5:  return 22'd242786;
            6:  return 22'd150050;
            7:  return 22'd92736;
            8:  return 22'd57314;
            9:  return 22'd35422;
            10: return 22'd21892;
            11: return 22'd13530;
            12: return 22'd8362;
            13: return 22'd5168;
            14: return 22'd3194;
            15: return 22'd1974;
            16: return 22'd1220;
            17: return 22'd754;
            18: return 22'd466;
            19: return 22'd288;
            20: return 22'd178;
            21: return 22'd110;
            22: return 22'd68;
            23: return 22'd42;
            24: return 22'd26;
            25: return 22'd16;
            26: return 22'd10;
            27: return 22'd6;
            28: return 22'd4;
            29: return 22'd2;
            30: return 22'd2;
            default: return 22'd0;
        endcase
    endfunction

    // Bit j of the shift register currently holds d[round*LANES + j + 1].
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            if (r_shift[j]) begin
                w_sum = w_sum + weight(int'(r_round) * LANES + j + 1);
            end
        end
    end

    assign w_last = (r_round == 5'(ROUNDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = ACC;
            ACC:     if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_round <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_shift <= in_code;
            r_acc   <= '0;
            r_round <= '0;
        end else if (r_state == ACC) begin
            r_shift <= r_shift >> LANES;
            r_acc   <= r_acc + w_sum;
            r_round <= r_round + 5'd1;
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == ACC) || (r_state == DONE);
    assign out_data  = out_valid ? r_acc[20:0] : 21'd0;
    // Sum fits in 22 bits, so bit 21 alone marks a value above 2097151.
    assign out_err   = out_valid && r_acc[21];

endmodule

// File: tb/tb_nbcac_21di_decoder_seq.sv
// Directed bench for nbcac_21di_decoder_seq with LANES = 1, 5 and 30 instances.
// Codewords for round-trip vectors come from a greedy NBCAC encoder model.
module tb_nbcac_21di_decoder_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_a [3];
    logic        in_ready_a [3];
    logic [29:0] in_code_a  [3];
    logic        out_valid_a[3];
    logic        out_ready_a[3];
    logic [20:0] out_data_a [3];
    logic        out_err_a  [3];
    logic        busy_a     [3];

    int checks = 0;
    int errors = 0;
    localparam int RND [3] = '{30, 6, 1};

    always #5 clk = ~clk;

    nbcac_21di_decoder_seq #(.LANES(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_code(in_code_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .out_data(out_data_a[0]), .out_err(out_err_a[0]), .busy(busy_a[0])
    );

    nbcac_21di_decoder_seq #(.LANES(5)) u_dut_l5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_code(in_code_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .out_data(out_data_a[1]), .out_err(out_err_a[1]), .busy(busy_a[1])
    );

    nbcac_21di_decoder_seq #(.LANES(30)) u_dut_l30 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .in_code(in_code_a[2]),
        .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
        .out_data(out_data_a[2]), .out_err(out_err_a[2]), .busy(busy_a[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Greedy encoding from the largest weight down always terminates at zero for v <= 2097151.
    function automatic logic [29:0] enc(input int v);
        int w [30] = '{1, 1028458, 635622, 392836, 242786, 150050, 92736, 57314, 35422,
                       21892, 13530, 8362, 5168, 3194, 1974, 1220, 754, 466, 288, 178,
                       110, 68, 42, 26, 16, 10, 6, 4, 2, 2};
        int rem;
        logic [29:0] c;
        rem = v;
        c = '0;
        for (int k = 1; k < 30; k++) begin
            if (w[k] <= rem) begin
                c[k] = 1'b1;
                rem -= w[k];
            end
        end
        if (rem >= 1) begin
            c[0] = 1'b1;
        end
        return c;
    endfunction

    task automatic decode(input int idx, input logic [29:0] code,
                          output logic [20:0] d, output logic e);
        int wt;
        int lat;
        wt = 0;
        @(negedge clk);
        while (!in_ready_a[idx] && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        chk("in_ready_idle", 32'(in_ready_a[idx]), 32'd1);
        in_valid_a[idx] = 1'b1;
        in_code_a[idx]  = code;
        @(negedge clk);
        in_valid_a[idx] = 1'b0;
        in_code_a[idx]  = 30'($urandom);
        lat = 0;
        while (!out_valid_a[idx] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(RND[idx]));
        chk("busy_done", 32'(busy_a[idx]), 32'd1);
        d = out_data_a[idx];
        e = out_err_a[idx];
        out_ready_a[idx] = 1'b1;
        @(negedge clk);
        out_ready_a[idx] = 1'b0;
        chk("valid_drop", 32'(out_valid_a[idx]), 32'd0);
        chk("ready_back", 32'(in_ready_a[idx]), 32'd1);
    endtask

    task automatic expect_code(input int idx, input string tag, input logic [29:0] code,
                               input int exp_d, input logic exp_e);
        logic [20:0] d;
        logic        e;
        decode(idx, code, d, e);
        chk(tag, 32'(d), 32'(exp_d));
        chk({tag, "_err"}, 32'(e), 32'(exp_e));
    endtask

    initial begin
        int rt_vals [6] = '{0, 1, 2, 1028457, 1028458, 2097151};
        int v;
        int wt;
        logic [20:0] d;
        logic        e;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            in_code_a[i]   = '0;
            out_ready_a[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_a[0]), 32'd0);
        chk("rst_out_valid", 32'(out_valid_a[0]), 32'd0);
        chk("rst_out_data", 32'(out_data_a[0]), 32'd0);
        chk("rst_busy", 32'(busy_a[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready_a[0]), 32'd1);
        chk("post_rst_out_err", 32'(out_err_a[0]), 32'd0);

        for (int i = 0; i < 3; i++) begin
            expect_code(i, "zero", 30'h0, 0, 1'b0);
            expect_code(i, "d1", 30'h0000_0001, 1, 1'b0);
            expect_code(i, "d2", 30'h0000_0002, 1028458, 1'b0);
            expect_code(i, "d30", 30'h2000_0000, 2, 1'b0);
            expect_code(i, "all_ones", 30'h3FFF_FFFF, 595385, 1'b1);
            expect_code(i, "d3_d29", 30'h1000_0004, 635624, 1'b0);
        end

        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 6; k++) begin
                expect_code(i, "roundtrip", enc(rt_vals[k]), rt_vals[k], 1'b0);
            end
            for (int k = 0; k < 40; k++) begin
                v = int'($urandom_range(2097151, 0));
                expect_code(i, "roundtrip_rand", enc(v), v, 1'b0);
            end
        end

        // Backpressure: result must hold while downstream stalls.
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_code_a[0]  = enc(123456);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        wt = 0;
        while (!out_valid_a[0] && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        chk("hold_reach_done", 32'(out_valid_a[0]), 32'd1);
        for (int k = 0; k < 7; k++) begin
            in_valid_a[0] = k[0];
            in_code_a[0]  = 30'($urandom);
            @(negedge clk);
            chk("hold_data", 32'(out_data_a[0]), 32'd123456);
            chk("hold_err", 32'(out_err_a[0]), 32'd0);
            chk("hold_in_ready", 32'(in_ready_a[0]), 32'd0);
            chk("hold_valid", 32'(out_valid_a[0]), 32'd1);
        end
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        chk("release_valid", 32'(out_valid_a[0]), 32'd0);
        chk("release_in_ready", 32'(in_ready_a[0]), 32'd1);
        @(negedge clk);
        chk("no_second_capture", 32'(busy_a[0]), 32'd0);

        // Abort mid-accumulation with an error-producing word in flight.
        in_valid_a[0] = 1'b1;
        in_code_a[0]  = 30'h3FFF_FFFF;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_abort_busy", 32'(busy_a[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid_a[0]), 32'd0);
        chk("abort_in_ready", 32'(in_ready_a[0]), 32'd0);
        chk("abort_busy", 32'(busy_a[0]), 32'd0);
        chk("abort_out_data", 32'(out_data_a[0]), 32'd0);
        chk("abort_out_err", 32'(out_err_a[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready_back", 32'(in_ready_a[0]), 32'd1);
        decode(0, enc(42), d, e);
        chk("after_abort_data", 32'(d), 32'd42);
        chk("after_abort_err", 32'(e), 32'd0);
        expect_code(2, "after_abort_l30", enc(777777), 777777, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
